datapath_controller: RTL and testbench
======================================

// Module: datapath_controller
// PURPOSE
//  Instruction-sequencing FSM for the 16-bit register/shifter/ALU datapath.
//  Latches one instruction on a start request and drives every datapath
//  control line, one micro-step per clock, until the result is written back
//  or the status flag is updated. Sits between the instruction source and the
//  datapath; its imm_out drives the datapath's datapath_in port.
// PARAMETERS
//  DATA_W  16  width of imm_out; imm8 is sign-extended to this width
// PORTS
//  clk       in   1       rising-edge clock, single clock domain
//  rst_n     in   1       asynchronous, active-low reset
//  s         in   1       start request, sampled only in WAIT
//  instr     in   16      instruction, captured into instr_q when s is accepted
//  w         out  1       1 = idle in WAIT and ready to accept s
//  done      out  1       1-cycle pulse on the final micro-step of a legal instruction
//  err       out  1       1-cycle pulse in DECODE when the opcode is undefined
//  imm_out   out  DATA_W  sign-extended instr_q[7:0]
//  vsel      out  1       write-back select: 1 = imm_out, 0 = datapath_out
//  write     out  1       register-file write enable
//  writenum  out  3       destination register number
//  readnum   out  3       source register number
//  loada     out  1       load enable for the A pipeline register
//  loadb     out  1       load enable for the B pipeline register
//  loadc     out  1       load enable for the C pipeline register
//  loads     out  1       load enable for the status (Z) register
//  asel      out  1       1 = A operand forced to 0
//  bsel      out  1       1 = B operand is {11'b0, imm5}
//  shift     out  2       shifter control
//  ALUop     out  2       ALU operation: 00 add, 01 sub, 10 and, 11 not-B
// BEHAVIOUR
//  Instruction fields: opcode=[15:13], op=[12:11], Rn=[10:8], Rd=[7:5],
//   sh=[4:3], Rm=[2:0], imm8=[7:0]. Fields are decoded from instr_q only.
//  FSM states: WAIT, DECODE, WR_IMM, GET_A, GET_B, COMPUTE, WR_REG.
//   Outputs are Moore outputs (function of state and instr_q only).
//  Reset: state=WAIT, instr_q=0; w=1; every other output is 0.
//  WAIT: w=1. If s=1, capture instr, then go to DECODE. If s=0, stay.
//  DECODE: no datapath strobes. Route by opcode/op:
//   110/10 MOV imm   -> WR_IMM
//   110/00 MOV reg   -> GET_B
//   101/00 ADD, 101/01 CMP, 101/10 AND -> GET_A
//   101/11 MVN       -> GET_B
//   Any other code   -> err=1, next state WAIT.
//  WR_IMM: vsel=1, writenum=Rn, write=1, done=1; next state WAIT.
//  GET_A: readnum=Rn, loada=1; next state GET_B.
//  GET_B: readnum=Rm, loadb=1; next state COMPUTE.
//  COMPUTE: shift=sh, bsel=0.
//   MOV reg: asel=1, ALUop=00.
//   MVN: asel=1, ALUop=11.
//   ADD/CMP/AND: asel=0, ALUop=op.
//   CMP: loads=1, loadc=0, done=1; next state WAIT.
//   All others: loadc=1, loads=0; next state WR_REG.
//  WR_REG: vsel=0, writenum=Rd, write=1, done=1; next state WAIT.
//  readnum, writenum, shift and ALUop are 0 in every state where they are
//   not listed above.
//  Latency from the s-accept edge to the done cycle, in clocks:
//   MOV imm 2, MOV reg 4, MVN 4, CMP 4, ADD 5, AND 5.
//   w re-asserts on the cycle after done.
//  Start handling: s is ignored while w=0. There is no queueing.
//   A new s may be accepted on the first cycle back in WAIT.
//  Reset mid-instruction: return to WAIT immediately. write and all load
//   strobes drop asynchronously. The partially executed instruction is discarded.
//  At most one of write, loada, loadb, loadc is 1 in any cycle.
//  loads=1 only in COMPUTE for CMP.
// TESTING
//  1. Reset, then s=1 with MOV R0,#-3 (16'hD0FD): imm_out=16'hFFFD, vsel=1,
//     writenum=0, write=1, done=1 two cycles after accept; then w=1.
//  2. ADD R2,R1,R0,LSL#1 (16'hA148): sequence GET_A(readnum=1,loada),
//     GET_B(readnum=0,loadb), COMPUTE(shift=01,ALUop=00,loadc),
//     WR_REG(writenum=2,write). With R1=2 and R0=5 in a real datapath,
//     R2=12 afterwards.
//  3. CMP R1,R1 (16'hA901): loads=1, write never 1, done in COMPUTE;
//     datapath Z_out=1 afterwards.
//  4. MVN R3,R0 (16'hB860): no GET_A; COMPUTE has asel=1, ALUop=11;
//     R0=16'h00F0 gives R3=16'hFF0F.
//  5. Undefined instruction 16'hE000: err pulses in DECODE; no write or
//     load strobes; back in WAIT 2 cycles after accept.
//  6. s held high throughout plus rst_n pulsed low during COMPUTE of an ADD:
//     all strobes 0 asynchronously; no write occurs; w=1; first s after
//     rst_n rises starts a fresh instruction.

Source files
------------

// File: rtl/datapath_controller.sv
// Instruction-sequencing FSM for the 16-bit register/shifter/ALU datapath.
// Latches one instruction on s and steps the datapath strobes one micro-step per clock.
module datapath_controller #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s,
    input  logic [15:0]       instr,
    output logic              w,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] imm_out,
    output logic              vsel,
    output logic              write,
    output logic [2:0]        writenum,
    output logic [2:0]        readnum,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop
);

    typedef enum logic [2:0] {
        WAIT, DECODE, WR_IMM, GET_A, GET_B, COMPUTE, WR_REG
    } state_t;

    state_t      state, next_state;
    logic [15:0] instr_q;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    logic       is_mov_imm, is_mov_reg, is_alu3, is_mvn, is_cmp;

    function automatic logic signed [DATA_W-1:0] sign_extend(input logic [7:0] v);
        return {{(DATA_W-8){v[7]}}, v};
    endfunction

    assign opcode = instr_q[15:13];
    assign op     = instr_q[12:11];
    assign rn     = instr_q[10:8];
    assign rd     = instr_q[7:5];
    assign sh     = instr_q[4:3];
    assign rm     = instr_q[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu3    = (opcode == 3'b101) && (op != 2'b11);
    assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);
    assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);

    assign imm_out = sign_extend(instr_q[7:0]);
    // No instruction in this set takes the imm5 B operand.
    assign bsel    = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WAIT;
            instr_q <= '0;
        end else begin
            state <= next_state;
            if (state == WAIT && s) instr_q <= instr;
        end
    end

    always_comb begin
        next_state = state;
        w          = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        vsel       = 1'b0;
        write      = 1'b0;
        writenum   = 3'd0;
        readnum    = 3'd0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        shift      = 2'b00;
        ALUop      = 2'b00;
        case (state)
            WAIT: begin
                w = 1'b1;
                if (s) next_state = DECODE;
            end
            DECODE: begin
                if (is_mov_imm)               next_state = WR_IMM;
                else if (is_mov_reg || is_mvn) next_state = GET_B;
                else if (is_alu3)             next_state = GET_A;
                else begin
                    err        = 1'b1;
                    next_state = WAIT;
                end
            end
            WR_IMM: begin
                vsel       = 1'b1;
                writenum   = rn;
                write      = 1'b1;
                done       = 1'b1;
                next_state = WAIT;
            end
            GET_A: begin
                readnum    = rn;
                loada      = 1'b1;
                next_state = GET_B;
            end
            GET_B: begin
                readnum    = rm;
                loadb      = 1'b1;
                next_state = COMPUTE;
            end
            COMPUTE: begin
                shift = sh;
                if (is_mov_reg) begin
                    asel  = 1'b1;
                    ALUop = 2'b00;
                end else if (is_mvn) begin
                    asel  = 1'b1;
                    ALUop = 2'b11;
                end else begin
                    ALUop = op;
                end
                // CMP only updates the status flag, so it finishes here.
                if (is_cmp) begin
                    loads      = 1'b1;
                    done       = 1'b1;
                    next_state = WAIT;
                end else begin
                    loadc      = 1'b1;
                    next_state = WR_REG;
                end
            end
            WR_REG: begin
                writenum   = rd;
                write      = 1'b1;
                done       = 1'b1;
                next_state = WAIT;
            end
            default: next_state = WAIT;
        endcase
    end

endmodule

// File: tb/tb_datapath_controller.sv
// Randomized bench for datapath_controller: per-instruction micro-step lists
// from a behavioural model, plus directed literal checks.
module tb_datapath_controller;

    logic        clk = 1'b0;
    logic        rst_n, s;
    logic [15:0] instr;
    logic        w, done, err, vsel, write, loada, loadb, loadc, loads, asel, bsel;
    logic [15:0] imm_out;
    logic [2:0]  writenum, readnum;
    logic [1:0]  shift, ALUop;

    int n_tests = 0;
    int n_fail  = 0;

    datapath_controller #(.DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .s(s), .instr(instr),
        .w(w), .done(done), .err(err), .imm_out(imm_out),
        .vsel(vsel), .write(write), .writenum(writenum), .readnum(readnum),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop)
    );

    always #5 clk = ~clk;

    // Control vector: {w,done,err,vsel,write,writenum,readnum,loada,loadb,loadc,loads,asel,bsel,shift,ALUop}
    localparam logic [20:0] IDLE = 21'h100000;
    logic [20:0] mq[$];
    logic [15:0] miq = 16'h0000;
    logic [20:0] exp_v, act_v;
    logic [15:0] exp_imm;

    function automatic logic [20:0] mk(input logic w_, done_, err_, vsel_, write_,
                                       input logic [2:0] wn, rn,
                                       input logic la, lb, lc, ls, as,
                                       input logic [1:0] sh, alu);
        return {w_, done_, err_, vsel_, write_, wn, rn, la, lb, lc, ls, as, 1'b0, sh, alu};
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    // Expected micro-steps of one instruction, starting with the DECODE cycle.
    task automatic push_seq(input logic [15:0] ins);
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op, sh, alu;
        logic movi, movr, alu3, mvn, cmp;
        opc = ins[15:13]; op = ins[12:11]; rn = ins[10:8];
        rd = ins[7:5]; sh = ins[4:3]; rm = ins[2:0];
        movi = (opc == 3'b110) && (op == 2'b10);
        movr = (opc == 3'b110) && (op == 2'b00);
        alu3 = (opc == 3'b101) && (op != 2'b11);
        mvn  = (opc == 3'b101) && (op == 2'b11);
        cmp  = (opc == 3'b101) && (op == 2'b01);
        if (!(movi || movr || alu3 || mvn)) begin
            mq.push_back(mk(0,0,1,0,0, 3'd0,3'd0, 0,0,0,0,0, 2'd0,2'd0));
        end else begin
            mq.push_back(mk(0,0,0,0,0, 3'd0,3'd0, 0,0,0,0,0, 2'd0,2'd0));
            if (movi) begin
                mq.push_back(mk(0,1,0,1,1, rn,3'd0, 0,0,0,0,0, 2'd0,2'd0));
            end else begin
                if (alu3) mq.push_back(mk(0,0,0,0,0, 3'd0,rn, 1,0,0,0,0, 2'd0,2'd0));
                mq.push_back(mk(0,0,0,0,0, 3'd0,rm, 0,1,0,0,0, 2'd0,2'd0));
                alu = movr ? 2'b00 : (mvn ? 2'b11 : op);
                mq.push_back(mk(0,cmp,0,0,0, 3'd0,3'd0, 0,0,!cmp,cmp,movr|mvn, sh,alu));
                if (!cmp) mq.push_back(mk(0,1,0,0,1, rd,3'd0, 0,0,0,0,0, 2'd0,2'd0));
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            miq = 16'h0000;
        end
        exp_v   = (mq.size() > 0) ? mq[0] : IDLE;
        exp_imm = sext8(miq[7:0]);
        act_v   = {w, done, err, vsel, write, writenum, readnum,
                   loada, loadb, loadc, loads, asel, bsel, shift, ALUop};
        n_tests++;
        if (act_v !== exp_v || imm_out !== exp_imm) begin
            n_fail++;
            $display("FAIL model t=%0t ctrl got %h exp %h imm got %h exp %h",
                     $time, act_v, exp_v, imm_out, exp_imm);
        end
        if (rst_n) begin
            if (mq.size() > 0) void'(mq.pop_front());
            else if (s) begin
                miq = instr;
                push_seq(instr);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s got %h exp %h", nm, got, expv);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            if (w === 1'b1) return;
            @(posedge clk); #1;
        end
        chk("wait_idle_timeout", {31'd0, w}, 32'd1);
    endtask

    // Accept ins, then measure cycles to done; returns still inside the done cycle.
    task automatic issue(input logic [15:0] ins, input int lat, input string nm);
        int n;
        wait_idle();
        s = 1'b1; instr = ins;
        @(posedge clk); #1;
        s = 1'b0;
        n = 1;
        while (n <= 8 && done !== 1'b1) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, n, lat);
    endtask

    function automatic logic [15:0] gen();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 7))
            0: r[15:11] = 5'b11010;
            1: r[15:11] = 5'b11000;
            2: r[15:11] = 5'b10100;
            3: r[15:11] = 5'b10101;
            4: r[15:11] = 5'b10110;
            5: r[15:11] = 5'b10111;
            6: r[15:11] = {4'b1100 | 4'($urandom_range(0, 1) * 2), 1'b1};
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        int n;
        rst_n = 1'b0; s = 1'b0; instr = 16'h0000;
        #2;
        chk("reset_w", {31'd0, w}, 32'd1);
        chk("reset_strobes", {done, err, write, loada, loadb, loadc, loads, vsel}, 8'h00);
        chk("reset_imm", imm_out, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        issue(16'hD0FD, 2, "movi_latency");
        chk("movi_imm", imm_out, 16'hFFFD);
        chk("movi_wr", {vsel, write, writenum}, {1'b1, 1'b1, 3'd0});
        @(posedge clk); #1;
        chk("movi_w_back", {31'd0, w}, 32'd1);

        wait_idle();
        s = 1'b1; instr = 16'hA148;
        @(posedge clk); #1; s = 1'b0;
        @(posedge clk); #1;
        chk("add_get_a", {readnum, loada, loadb}, {3'd1, 1'b1, 1'b0});
        @(posedge clk); #1;
        chk("add_get_b", {readnum, loada, loadb}, {3'd0, 1'b0, 1'b1});
        @(posedge clk); #1;
        chk("add_compute", {shift, ALUop, asel, loadc, write}, {2'b01, 2'b00, 1'b0, 1'b1, 1'b0});
        @(posedge clk); #1;
        chk("add_wr_reg", {writenum, write, done, vsel}, {3'd2, 1'b1, 1'b1, 1'b0});

        issue(16'hA901, 4, "cmp_latency");
        chk("cmp_compute", {loads, loadc, write, ALUop}, {1'b1, 1'b0, 1'b0, 2'b01});

        issue(16'hB860, 4, "mvn_latency");
        chk("mvn_wr", {writenum, write}, {3'd3, 1'b1});
        issue(16'hC01A, 4, "movr_latency");
        issue(16'hB000, 5, "and_latency");

        wait_idle();
        s = 1'b1; instr = 16'hE000;
        @(posedge clk); #1; s = 1'b0;
        chk("undef_err", {err, write, loada, loadb, loadc, loads}, 6'b100000);
        @(posedge clk); #1;
        chk("undef_w_back", {err, w}, 2'b01);

        // Reset during COMPUTE of an ADD with s held high.
        wait_idle();
        s = 1'b1; instr = 16'hA148;
        @(posedge clk); #1;
        n = 0;
        while (n < 10 && loadc !== 1'b1) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_reach_compute", {31'd0, loadc}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_strobes", {write, loada, loadb, loadc, loads, done}, 6'd0);
        chk("rst_async_w", {31'd0, w}, 32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_idle_after", {w, write}, 2'b10);
        @(posedge clk); #1;
        chk("rst_fresh_accept", {31'd0, w}, 32'd0);
        n = 1;
        while (n <= 8 && done !== 1'b1) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_fresh_latency", n, 5);
        s = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            s = ($urandom_range(0, 3) != 0);
            instr = gen();
        end
        s = 1'b0;
        wait_idle();
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
